// File: rtl/irq_ack_responder_if.sv
// Handshake bundle between the IPL encoder/CPU model and irq_ack_responder.
interface irq_ack_responder_if;
    logic       CLK_EN;
    logic       IPL0;
    logic       IPL1;
    logic [2:0] MASK;
    logic       SERVICE_DONE;
    logic       IRQ_REQ;
    logic [1:0] IRQ_LEVEL;
    logic       VEC_STB;
    logic [7:0] VECTOR;
    logic       WR_ACK;
    logic [2:0] ACK_BITS;
    logic       BUSY;
    logic       ERR;

    // Encoder / CPU side
    modport master (
        output CLK_EN, IPL0, IPL1, MASK, SERVICE_DONE,
        input  IRQ_REQ, IRQ_LEVEL, VEC_STB, VECTOR, WR_ACK, ACK_BITS, BUSY, ERR
    );

    // Responder side
    modport slave (
        input  CLK_EN, IPL0, IPL1, MASK, SERVICE_DONE,
        output IRQ_REQ, IRQ_LEVEL, VEC_STB, VECTOR, WR_ACK, ACK_BITS, BUSY, ERR
    );
endinterface

// File: rtl/irq_ack_responder.sv
// CPU-side interrupt responder: synchronizes and filters the encoded IPL lines,
// accepts a level above the mask, issues an autovector, waits for the handler
// and strobes the matching acknowledge back to the encoder.
module irq_ack_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IACK_CYCLES = 4,
    parameter int unsigned ACK_PULSE   = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic               CLK,
    input  logic               nRESET,
    irq_ack_responder_if.slave bus
);

    localparam int unsigned CNT_W        = 8;
    localparam int unsigned SETTLE_TICKS = SYNC_STAGES + 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEPT  = 3'd1,
        SERVICE = 3'd2,
        ACK     = 3'd3,
        SETTLE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irq_req_q, irq_req_d;
    logic [1:0]         irq_level_q, irq_level_d;
    logic               vec_stb_q, vec_stb_d;
    logic [7:0]         vector_q, vector_d;
    logic               wr_ack_q, wr_ack_d;
    logic [2:0]         ack_bits_q, ack_bits_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               done_pend_q, done_pend_d;

    logic [SYNC_STAGES-1:0] ipl0_sync_q, ipl1_sync_q;
    logic [1:0]             lvl_c;
    logic [1:0]             lvl_prev_q;
    logic [1:0]             fl_lvl_q;
    logic [1:0]             eff_level_c;
    logic [CNT_W-1:0]       cnt_inc_c;

    // True once cnt has seen n ticks (n=0 terminates on the first tick)
    function automatic logic at_count(input logic [CNT_W-1:0] cnt, input int unsigned n);
        return (32'(cnt) + 32'd1) >= n;
    endfunction

    // Level to acknowledge bit: reset=bit0, timer=bit1, VBL=bit2
    function automatic logic [2:0] onehot_ack(input logic [1:0] lvl);
        case (lvl)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // IPL synchronizer runs every clock; idle lines are high
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            ipl0_sync_q <= '1;
            ipl1_sync_q <= '1;
        end else begin
            ipl0_sync_q <= {ipl0_sync_q[SYNC_STAGES-2:0], bus.IPL0};
            ipl1_sync_q <= {ipl1_sync_q[SYNC_STAGES-2:0], bus.IPL1};
        end
    end

    assign lvl_c = {~ipl1_sync_q[SYNC_STAGES-1], ~ipl0_sync_q[SYNC_STAGES-1]};

    // Glitch filter: accept a level seen on two consecutive enabled ticks
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            lvl_prev_q <= 2'd0;
            fl_lvl_q   <= 2'd0;
        end else if (bus.CLK_EN) begin
            lvl_prev_q <= lvl_c;
            if (lvl_c == lvl_prev_q) begin
                fl_lvl_q <= lvl_c;
            end
        end
    end

    assign eff_level_c = (fl_lvl_q > irq_level_q) ? fl_lvl_q : irq_level_q;
    assign cnt_inc_c   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // State and registered outputs
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            irq_req_q   <= 1'b0;
            irq_level_q <= 2'd0;
            vec_stb_q   <= 1'b0;
            vector_q    <= 8'd0;
            wr_ack_q    <= 1'b1;
            ack_bits_q  <= 3'd0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            done_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            irq_req_q   <= irq_req_d;
            irq_level_q <= irq_level_d;
            vec_stb_q   <= vec_stb_d;
            vector_q    <= vector_d;
            wr_ack_q    <= wr_ack_d;
            ack_bits_q  <= ack_bits_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            done_pend_q <= done_pend_d;
        end
    end

    // Next-state and output logic; everything advances only on CLK_EN ticks
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        irq_req_d   = irq_req_q;
        irq_level_d = irq_level_q;
        vec_stb_d   = 1'b0;
        vector_d    = vector_q;
        wr_ack_d    = wr_ack_q;
        ack_bits_d  = ack_bits_q;
        err_d       = err_q;
        done_pend_d = done_pend_q;

        case (state_q)
            IDLE: begin
                done_pend_d = 1'b0;
                if (bus.CLK_EN && (fl_lvl_q != 2'd0) && ({1'b0, fl_lvl_q} > bus.MASK)) begin
                    irq_level_d = fl_lvl_q;
                    irq_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = ACCEPT;
                end
            end
            ACCEPT: begin
                if (bus.CLK_EN) begin
                    irq_level_d = eff_level_c;
                    if (at_count(cnt_q, IACK_CYCLES)) begin
                        vec_stb_d = 1'b1;
                        vector_d  = 8'd24 + 8'(eff_level_c);
                        irq_req_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = SERVICE;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
            end
            SERVICE: begin
                // A done pulse on a disabled clock is held until the next tick
                if (bus.CLK_EN) begin
                    if (bus.SERVICE_DONE || done_pend_q) begin
                        wr_ack_d    = 1'b0;
                        ack_bits_d  = onehot_ack(irq_level_q);
                        cnt_d       = '0;
                        done_pend_d = 1'b0;
                        state_d     = ACK;
                    end else if (at_count(cnt_q, TIMEOUT)) begin
                        err_d       = 1'b1;
                        wr_ack_d    = 1'b0;
                        ack_bits_d  = onehot_ack(irq_level_q);
                        cnt_d       = '0;
                        done_pend_d = 1'b0;
                        state_d     = ACK;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end else if (bus.SERVICE_DONE) begin
                    done_pend_d = 1'b1;
                end
            end
            ACK: begin
                if (bus.CLK_EN) begin
                    if (at_count(cnt_q, ACK_PULSE)) begin
                        wr_ack_d   = 1'b1;
                        ack_bits_d = 3'd0;
                        cnt_d      = '0;
                        state_d    = SETTLE;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
            end
            SETTLE: begin
                if (bus.CLK_EN) begin
                    if (at_count(cnt_q, SETTLE_TICKS)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.IRQ_REQ   = irq_req_q;
    assign bus.IRQ_LEVEL = irq_level_q;
    assign bus.VEC_STB   = vec_stb_q;
    assign bus.VECTOR    = vector_q;
    assign bus.WR_ACK    = wr_ack_q;
    assign bus.ACK_BITS  = ack_bits_q;
    assign bus.BUSY      = busy_q;
    assign bus.ERR       = err_q;

endmodule

// File: tb/tb_irq_ack_responder.sv
// Directed bench for irq_ack_responder: table of single-interrupt transactions
// followed by hand-written glitch, preempt, freeze, timeout and reset sequences.
module tb_irq_ack_responder;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    irq_ack_responder_if bus_if ();

    irq_ack_responder #(
        .SYNC_STAGES (2),
        .IACK_CYCLES (4),
        .ACK_PULSE   (2),
        .TIMEOUT     (255)
    ) dut (
        .CLK    (clk),
        .nRESET (rst_n),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ipl1;
        logic       ipl0;
        logic [2:0] mask;
        bit         acc;
        logic [1:0] lvl;
        logic [7:0] vec;
        logic [2:0] bits;
    } vec_t;

    localparam int W_IRQ   = 0;
    localparam int W_VEC   = 1;
    localparam int W_ACKLO = 2;
    localparam int W_IDLE  = 3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            W_IRQ:   return bus_if.IRQ_REQ === 1'b1;
            W_VEC:   return bus_if.VEC_STB === 1'b1;
            W_ACKLO: return bus_if.WR_ACK === 1'b0;
            default: return bus_if.BUSY === 1'b0;
        endcase
    endfunction

    // Ticks until the condition holds; -1 when the budget runs out
    task automatic wait_until(input int which, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (cond(which)) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic set_ipl(input logic i1, input logic i0);
        bus_if.IPL1 = i1;
        bus_if.IPL0 = i0;
    endtask

    task automatic pulse_done();
        bus_if.SERVICE_DONE = 1'b1;
        tick();
        bus_if.SERVICE_DONE = 1'b0;
    endtask

    // From an accepted request: vector, acknowledge pulse, return to idle
    task automatic finish_txn(input string tag, input logic [7:0] exp_vec, input logic [2:0] exp_bits);
        int n;
        int m;
        wait_until(W_VEC, 20, n);
        check({tag, "_vec_lat"}, 32'(n), 32'd4);
        check({tag, "_vector"}, 32'(bus_if.VECTOR), 32'(exp_vec));
        check({tag, "_req_clr"}, 32'(bus_if.IRQ_REQ), 32'd0);
        set_ipl(1'b1, 1'b1);
        repeat (3) tick();
        check({tag, "_svc_wait"}, 32'(bus_if.WR_ACK), 32'd1);
        pulse_done();
        m = 0;
        while (bus_if.WR_ACK === 1'b0 && m < 10) begin
            check({tag, "_ack_bits"}, 32'(bus_if.ACK_BITS), 32'(exp_bits));
            m++;
            tick();
        end
        check({tag, "_ack_len"}, 32'(m), 32'd2);
        check({tag, "_bits_clr"}, 32'(bus_if.ACK_BITS), 32'd0);
        wait_until(W_IDLE, 20, n);
        check({tag, "_idle"}, 32'(n > 0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   n;
        bit   flag;

        vt[0] = '{1'b1, 1'b0, 3'd0, 1'b1, 2'd1, 8'd25, 3'b100};
        vt[1] = '{1'b0, 1'b1, 3'd2, 1'b0, 2'd0, 8'd0,  3'b000};
        vt[2] = '{1'b0, 1'b1, 3'd1, 1'b1, 2'd2, 8'd26, 3'b010};
        vt[3] = '{1'b0, 1'b0, 3'd2, 1'b1, 2'd3, 8'd27, 3'b001};
        vt[4] = '{1'b0, 1'b0, 3'd3, 1'b0, 2'd0, 8'd0,  3'b000};
        vt[5] = '{1'b1, 1'b0, 3'd1, 1'b0, 2'd0, 8'd0,  3'b000};

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus_if.CLK_EN       = 1'b1;
        bus_if.MASK         = 3'd0;
        bus_if.SERVICE_DONE = 1'b0;
        set_ipl(1'b1, 1'b1);
        repeat (3) tick();

        check("rst_irq_req", 32'(bus_if.IRQ_REQ), 32'd0);
        check("rst_level", 32'(bus_if.IRQ_LEVEL), 32'd0);
        check("rst_vec_stb", 32'(bus_if.VEC_STB), 32'd0);
        check("rst_vector", 32'(bus_if.VECTOR), 32'd0);
        check("rst_wr_ack", 32'(bus_if.WR_ACK), 32'd1);
        check("rst_ack_bits", 32'(bus_if.ACK_BITS), 32'd0);
        check("rst_busy", 32'(bus_if.BUSY), 32'd0);
        check("rst_err", 32'(bus_if.ERR), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) begin
            set_ipl(vt[i].ipl1, vt[i].ipl0);
            bus_if.MASK = vt[i].mask;
            if (vt[i].acc) begin
                wait_until(W_IRQ, 30, n);
                check($sformatf("v%0d_accept", i), 32'(n > 0), 32'd1);
                if (n > 0) begin
                    check($sformatf("v%0d_level", i), 32'(bus_if.IRQ_LEVEL), 32'(vt[i].lvl));
                    check($sformatf("v%0d_busy", i), 32'(bus_if.BUSY), 32'd1);
                    finish_txn($sformatf("v%0d", i), vt[i].vec, vt[i].bits);
                end
            end else begin
                flag = 1'b0;
                repeat (20) begin
                    tick();
                    if (bus_if.BUSY !== 1'b0 || bus_if.IRQ_REQ !== 1'b0) flag = 1'b1;
                end
                check($sformatf("v%0d_masked", i), 32'(flag), 32'd0);
                set_ipl(1'b1, 1'b1);
            end
            repeat (8) tick();
        end

        // Single-tick glitch on IPL0 never reaches the filter output
        bus_if.MASK = 3'd0;
        set_ipl(1'b1, 1'b0);
        tick();
        set_ipl(1'b1, 1'b1);
        flag = 1'b0;
        repeat (15) begin
            tick();
            if (bus_if.BUSY !== 1'b0 || bus_if.IRQ_REQ !== 1'b0) flag = 1'b1;
        end
        check("glitch_idle", 32'(flag), 32'd0);

        // VBL accepted, reset level overtakes it during ACCEPT
        set_ipl(1'b1, 1'b0);
        tick();
        tick();
        set_ipl(1'b0, 1'b0);
        wait_until(W_IRQ, 30, n);
        check("pre_accept", 32'(n > 0), 32'd1);
        check("pre_level_first", 32'(bus_if.IRQ_LEVEL), 32'd1);
        if (n > 0) finish_txn("pre", 8'd27, 3'b001);
        repeat (8) tick();

        // CLK_EN low freezes the IACK count
        set_ipl(1'b1, 1'b0);
        wait_until(W_IRQ, 30, n);
        check("frz_accept", 32'(n > 0), 32'd1);
        bus_if.CLK_EN = 1'b0;
        flag = 1'b0;
        repeat (6) begin
            tick();
            if (bus_if.VEC_STB !== 1'b0) flag = 1'b1;
        end
        check("frz_no_vec", 32'(flag), 32'd0);
        check("frz_busy", 32'(bus_if.BUSY), 32'd1);
        bus_if.CLK_EN = 1'b1;
        if (n > 0) finish_txn("frz", 8'd25, 3'b100);
        repeat (8) tick();

        // Timer level with no handler completion: forced acknowledge
        set_ipl(1'b0, 1'b1);
        wait_until(W_IRQ, 30, n);
        check("to_accept", 32'(n > 0), 32'd1);
        wait_until(W_VEC, 20, n);
        check("to_vec_lat", 32'(n), 32'd4);
        check("to_err_before", 32'(bus_if.ERR), 32'd0);
        set_ipl(1'b1, 1'b1);
        wait_until(W_ACKLO, 400, n);
        check("to_latency", 32'(n), 32'd255);
        check("to_err_set", 32'(bus_if.ERR), 32'd1);
        check("to_ack_bits", 32'(bus_if.ACK_BITS), 32'b010);
        wait_until(W_IDLE, 20, n);
        repeat (10) tick();
        check("to_err_sticky", 32'(bus_if.ERR), 32'd1);

        // Reset while WR_ACK is low
        set_ipl(1'b1, 1'b0);
        wait_until(W_IRQ, 30, n);
        check("rack_accept", 32'(n > 0), 32'd1);
        wait_until(W_VEC, 20, n);
        set_ipl(1'b1, 1'b1);
        pulse_done();
        check("rack_low", 32'(bus_if.WR_ACK), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rack_wr_ack", 32'(bus_if.WR_ACK), 32'd1);
        check("rack_bits", 32'(bus_if.ACK_BITS), 32'd0);
        check("rack_busy", 32'(bus_if.BUSY), 32'd0);
        check("rack_err", 32'(bus_if.ERR), 32'd0);
        check("rack_level", 32'(bus_if.IRQ_LEVEL), 32'd0);
        tick();
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (20) begin
            tick();
            if (bus_if.WR_ACK !== 1'b1 || bus_if.BUSY !== 1'b0) flag = 1'b1;
        end
        check("rack_no_resume", 32'(flag), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
